mc_mips_core: RTL and testbench

- Multicycle MIPS core: one shared ALU, one unified memory port with a valid/ready handshake, and an internal control FSM.
- Successor to the single-cycle datapath. Adds variable memory wait states, lui, bne and illegal-opcode trapping.
- Sits between the testbench/SoC top and a single instruction+data memory.

---
 rtl/mc_mips_pkg.sv | 41 ++++
 rtl/mc_mips_ctrl.sv | 153 +++++++++++++++
 rtl/mc_mips_core.sv | 123 ++++++++++++
 tb/tb_mc_mips_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_mips_pkg.sv
// Shared opcodes, functs, ALU controls, FSM states and mux selects for mc_mips_core.
package mc_mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111, ALU_SLL = 4'b1000, ALU_SRL = 4'b1001
  } alu_ctl_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [1:0] {SRCA_PC, SRCA_A, SRCA_ZERO} srca_t;
  typedef enum logic [2:0] {SRCB_B, SRCB_FOUR, SRCB_SIMM, SRCB_SIMM_SH2, SRCB_ZIMM, SRCB_LUI} srcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_A} pc_src_t;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} rf_dst_t;
  typedef enum logic [1:0] {WD_ALUOUT, WD_MDR, WD_PC} rf_src_t;

  function automatic logic [31:0] alu_calc(alu_ctl_t ctl, logic [31:0] a, logic [31:0] b,
                                           logic [4:0] shamt);
    case (ctl)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: return b << shamt;
      ALU_SRL: return b >> shamt;
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_mips_ctrl.sv
// Control FSM of the multicycle MIPS core: mux selects, enables and memory handshake.
// MC_MIPS_JAL_EN adds jal and jr; without it both encodings trap.
module mc_mips_ctrl
  import mc_mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_cond,
  output logic       branch_ne,
  output logic       ab_we,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       rf_we,
  output pc_src_t    pc_src,
  output rf_dst_t    rf_dst,
  output rf_src_t    rf_src,
  output srca_t      srca,
  output srcb_t      srcb,
  output alu_ctl_t   alu_ctl,
  output logic       retire,
  output logic       trap
);

  state_t   state, state_next;
  logic     armed, req_state, hs, funct_ok, is_jr;
  alu_ctl_t funct_ctl;

  // armed keeps mem_req low for the first cycle after reset so an aborted access is visibly dropped
  assign req_state = armed && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign hs        = req_state && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  always_comb begin
    funct_ok  = 1'b1;
    is_jr     = 1'b0;
    funct_ctl = ALU_ADD;
    case (funct)
      FN_ADD: funct_ctl = ALU_ADD;
      FN_SUB: funct_ctl = ALU_SUB;
      FN_AND: funct_ctl = ALU_AND;
      FN_OR:  funct_ctl = ALU_OR;
      FN_SLT: funct_ctl = ALU_SLT;
      FN_SLL: funct_ctl = ALU_SLL;
      FN_SRL: funct_ctl = ALU_SRL;
`ifdef MC_MIPS_JAL_EN
      FN_JR:  is_jr = 1'b1;
`endif
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (hs) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             state_next = S_MEMADR;
          OP_RTYPE:                 state_next = S_EXEC;
          OP_ADDI, OP_ORI, OP_LUI:  state_next = S_IMMEX;
          OP_BEQ, OP_BNE:           state_next = S_BRANCH;
          OP_J:                     state_next = S_JUMP;
`ifdef MC_MIPS_JAL_EN
          OP_JAL:                   state_next = S_JUMP;
`endif
          default:                  state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (hs) state_next = S_MEMWB;
      S_MEMWR:  if (hs) state_next = S_FETCH;
      S_EXEC:   state_next = !funct_ok ? S_TRAP : (is_jr ? S_FETCH : S_ALUWB);
      S_IMMEX:  state_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = req_state;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_cond   = 1'b0;
    branch_ne = (opcode == OP_BNE);
    ab_we     = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_src    = PC_ALU;
    rf_dst    = DST_RT;
    rf_src    = WD_ALUOUT;
    srca      = SRCA_A;
    srcb      = SRCB_B;
    alu_ctl   = ALU_ADD;
    retire    = 1'b0;
    trap      = 1'b0;
    case (state)
      S_FETCH:  begin srca = SRCA_PC; srcb = SRCB_FOUR; ir_we = hs; pc_we = hs; end
      S_DECODE: begin srca = SRCA_PC; srcb = SRCB_SIMM_SH2; ab_we = 1'b1; aluout_we = 1'b1; end
      S_MEMADR: begin srcb = SRCB_SIMM; aluout_we = 1'b1; end
      S_MEMRD:  begin addr_sel = 1'b1; mdr_we = hs; end
      S_MEMWB:  begin rf_we = 1'b1; rf_src = WD_MDR; retire = 1'b1; end
      S_MEMWR:  begin addr_sel = 1'b1; mem_we = armed; retire = hs; end
      S_EXEC: begin
        alu_ctl   = funct_ctl;
        aluout_we = 1'b1;
        if (is_jr) begin pc_we = 1'b1; pc_src = PC_A; retire = 1'b1; end
      end
      S_ALUWB:  begin rf_we = 1'b1; rf_dst = DST_RD; retire = 1'b1; end
      S_IMMEX: begin
        aluout_we = 1'b1;
        case (opcode)
          OP_ORI:  begin srcb = SRCB_ZIMM; alu_ctl = ALU_OR; end
          OP_LUI:  begin srca = SRCA_ZERO; srcb = SRCB_LUI; alu_ctl = ALU_OR; end
          default: srcb = SRCB_SIMM;
        endcase
      end
      S_IMMWB:  begin rf_we = 1'b1; retire = 1'b1; end
      S_BRANCH: begin alu_ctl = ALU_SUB; pc_cond = 1'b1; pc_src = PC_ALUOUT; retire = 1'b1; end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
        retire = 1'b1;
`ifdef MC_MIPS_JAL_EN
        if (opcode == OP_JAL) begin rf_we = 1'b1; rf_dst = DST_RA; rf_src = WD_PC; end
`endif
      end
      S_TRAP:   trap = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mc_mips_core.sv
// Multicycle MIPS core datapath: register file, shared ALU, IR/A/B/ALUOut/MDR and one memory port.
// MC_MIPS_JAL_EN (handled in mc_mips_ctrl) enables jal/jr.
module mc_mips_core
  import mc_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              trap
);

  logic [31:0] ir, a_reg, b_reg, aluout, mdr;
  logic [31:0] rf [32];
  logic [31:0] signimm, src_a, src_b, alu_result, pc_next, rf_wd;
  logic [4:0]  rf_wa;
  logic        zero, pc_en;
  logic        addr_sel, ir_we, pc_we, pc_cond, branch_ne, ab_we, aluout_we, mdr_we, rf_we;
  pc_src_t     pc_src;
  rf_dst_t     rf_dst;
  rf_src_t     rf_src;
  srca_t       srca;
  srcb_t       srcb;
  alu_ctl_t    alu_ctl;

  wire [5:0]  opcode = ir[31:26];
  wire [4:0]  rs     = ir[25:21];
  wire [4:0]  rt     = ir[20:16];
  wire [4:0]  rd     = ir[15:11];
  wire [4:0]  shamt  = ir[10:6];
  wire [15:0] imm    = ir[15:0];

  assign signimm = {{16{imm[15]}}, imm};

  mc_mips_ctrl u_ctrl (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(ir[5:0]), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_cond(pc_cond), .branch_ne(branch_ne), .ab_we(ab_we), .aluout_we(aluout_we),
    .mdr_we(mdr_we), .rf_we(rf_we), .pc_src(pc_src), .rf_dst(rf_dst), .rf_src(rf_src),
    .srca(srca), .srcb(srcb), .alu_ctl(alu_ctl), .retire(retire), .trap(trap)
  );

  always_comb begin
    src_a = a_reg;
    case (srca)
      SRCA_PC:   src_a = pc;
      SRCA_ZERO: src_a = 32'b0;
      default:   src_a = a_reg;
    endcase
    src_b = b_reg;
    case (srcb)
      SRCB_FOUR:     src_b = 32'd4;
      SRCB_SIMM:     src_b = signimm;
      SRCB_SIMM_SH2: src_b = {signimm[29:0], 2'b00};
      SRCB_ZIMM:     src_b = {16'b0, imm};
      SRCB_LUI:      src_b = {imm, 16'b0};
      default:       src_b = b_reg;
    endcase
  end

  assign alu_result = alu_calc(alu_ctl, src_a, src_b, shamt);
  assign zero       = (alu_result == 32'b0);
  assign pc_en      = pc_we || (pc_cond && (zero ^ branch_ne));

  always_comb begin
    pc_next = alu_result;
    case (pc_src)
      PC_ALUOUT: pc_next = aluout;
      PC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PC_A:      pc_next = a_reg;
      default:   pc_next = alu_result;
    endcase
    rf_wa = rt;
    case (rf_dst)
      DST_RD:  rf_wa = rd;
      DST_RA:  rf_wa = 5'd31;
      default: rf_wa = rt;
    endcase
    rf_wd = aluout;
    case (rf_src)
      WD_MDR:  rf_wd = mdr;
      WD_PC:   rf_wd = pc;
      default: rf_wd = aluout;
    endcase
  end

  // Address and store data read as zero whenever no transfer is in flight
  assign mem_addr  = !mem_req ? '0 : (addr_sel ? aluout[ADDR_W-1:0] : pc[ADDR_W-1:0]);
  assign mem_wdata = mem_we ? b_reg : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= 32'b0;
      a_reg  <= 32'b0;
      b_reg  <= 32'b0;
      aluout <= 32'b0;
      mdr    <= 32'b0;
    end else begin
      if (pc_en)     pc     <= pc_next;
      if (ir_we)     ir     <= mem_rdata;
      if (ab_we)     a_reg  <= (rs == 5'd0) ? 32'b0 : rf[rs];
      if (ab_we)     b_reg  <= (rt == 5'd0) ? 32'b0 : rf[rt];
      if (aluout_we) aluout <= alu_result;
      if (mdr_we)    mdr    <= mem_rdata;
    end
  end

  // Register file is deliberately not reset; $0 is never written
  always_ff @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
  end

endmodule

// File: tb/tb_mc_mips_core.sv
// Scoreboard bench for mc_mips_core: program table pushes expected reads, writes and retire gaps.
module tb_mc_mips_core;

  logic        clk, reset, mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic [31:0] mem [256];
  logic [31:0] exp_rd [$];
  logic [63:0] exp_wr [$];
  int          exp_gap [$];
  int          checks = 0, errors = 0;
  logic        stall = 1'b0, mon_en = 1'b0;
  int          data_wait = 3;

  mc_mips_core #(.RESET_PC(32'h40), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] instr, input int gap,
                               input bit has_wr, input logic [31:0] wa, input logic [31:0] wd,
                               input bit has_drd, input logic [31:0] dra);
    mem[addr[9:2]] = instr;
    exp_rd.push_back(addr);
    if (has_drd) exp_rd.push_back(dra);
    if (has_wr) exp_wr.push_back({wa, wd});
    if (gap > 0) exp_gap.push_back(gap);
  endtask

  task automatic tick;
    @(negedge clk);
    #3;
  endtask

  // Memory responder: data reads below 0x40 get data_wait wait states, stall blocks everything
  always begin
    int wait_cnt;
    int need;
    @(negedge clk);
    if (!mem_req) begin
      mem_ready = 1'b1;
      wait_cnt  = 0;
    end else begin
      need = (!mem_we && mem_addr < 32'h40) ? data_wait : 0;
      if (stall || wait_cnt < need) begin
        mem_ready = 1'b0;
        if (!stall) wait_cnt++;
      end else begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and retire
  initial begin
    int          cyc, prev_cyc;
    bit          have_prev, prev_stall, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    logic [63:0] e;
    cyc = 0; prev_cyc = 0; have_prev = 0; prev_stall = 0; prev_we = 0;
    prev_addr = 0; prev_wdata = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (reset || !mon_en) begin
        have_prev  = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall && mem_req) begin
          checkOutput("hold_addr", mem_addr, prev_addr);
          checkOutput("hold_we", {31'b0, mem_we}, {31'b0, prev_we});
          checkOutput("hold_wdata", mem_wdata, prev_wdata);
        end
        if (mem_req && mem_ready) begin
          if (mem_we) begin
            if (exp_wr.size() == 0) begin
              checks++; errors++;
              $display("[TB] FAIL wr_unexpected: got addr 0x%08h data 0x%08h, expected none", mem_addr, mem_wdata);
            end else begin
              e = exp_wr.pop_front();
              checkOutput("wr_addr", mem_addr, e[63:32]);
              checkOutput("wr_data", mem_wdata, e[31:0]);
            end
          end else begin
            if (exp_rd.size() == 0) begin
              checks++; errors++;
              $display("[TB] FAIL rd_unexpected: got addr 0x%08h, expected none", mem_addr);
            end else checkOutput("rd_addr", mem_addr, exp_rd.pop_front());
          end
        end
        if (retire) begin
          if (have_prev) begin
            if (exp_gap.size() == 0) begin
              checks++; errors++;
              $display("[TB] FAIL retire_unexpected: got gap %0d, expected none", cyc - prev_cyc);
            end else checkOutput("retire_gap", cyc - prev_cyc, exp_gap.pop_front());
          end
          have_prev = 1;
          prev_cyc  = cyc;
        end
        prev_stall = mem_req && !mem_ready;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;

    applyStimulus(32'h40, 32'h2001_0005, 0, 0, 0, 0, 0, 0);                  // addi $1,$0,5
    applyStimulus(32'h44, 32'h2002_0007, 4, 0, 0, 0, 0, 0);                  // addi $2,$0,7
    applyStimulus(32'h48, 32'h0022_1820, 4, 0, 0, 0, 0, 0);                  // add $3,$1,$2
    applyStimulus(32'h4C, 32'hAC03_0008, 4, 1, 32'h08, 32'd12, 0, 0);        // sw $3,8($0)
    applyStimulus(32'h50, 32'h8C04_0008, 8, 0, 0, 0, 1, 32'h08);             // lw $4,8($0), 3 waits
    applyStimulus(32'h54, 32'h1021_0002, 3, 0, 0, 0, 0, 0);                  // beq $1,$1,+2
    applyStimulus(32'h60, 32'h1421_0002, 3, 0, 0, 0, 0, 0);                  // bne $1,$1,+2
    applyStimulus(32'h64, 32'h3C05_ABCD, 4, 0, 0, 0, 0, 0);                  // lui $5,0xABCD
    applyStimulus(32'h68, 32'h34A5_1234, 4, 0, 0, 0, 0, 0);                  // ori $5,$5,0x1234
    applyStimulus(32'h6C, 32'h0005_3100, 4, 0, 0, 0, 0, 0);                  // sll $6,$5,4
    applyStimulus(32'h70, 32'hAC06_000C, 4, 1, 32'h0C, 32'hBCD1_2340, 0, 0); // sw $6,12($0)
    applyStimulus(32'h74, 32'hAC04_0010, 4, 1, 32'h10, 32'd12, 0, 0);        // sw $4,16($0)
    applyStimulus(32'h78, 32'hAC05_0014, 4, 1, 32'h14, 32'hABCD_1234, 0, 0); // sw $5,20($0)
    applyStimulus(32'h7C, 32'h0800_0024, 3, 0, 0, 0, 0, 0);                  // j 0x90
    applyStimulus(32'h90, 32'h0022_3822, 4, 0, 0, 0, 0, 0);                  // sub $7,$1,$2
    applyStimulus(32'h94, 32'h00E1_402A, 4, 0, 0, 0, 0, 0);                  // slt $8,$7,$1
    applyStimulus(32'h98, 32'hAC07_0018, 4, 1, 32'h18, 32'hFFFF_FFFE, 0, 0); // sw $7,24($0)
    applyStimulus(32'h9C, 32'hAC08_001C, 4, 1, 32'h1C, 32'd1, 0, 0);         // sw $8,28($0)
    applyStimulus(32'hA0, 32'h2000_0009, 4, 0, 0, 0, 0, 0);                  // addi $0,$0,9
    applyStimulus(32'hA4, 32'hAC00_0020, 4, 1, 32'h20, 32'd0, 0, 0);         // sw $0,32($0)
    applyStimulus(32'hA8, 32'hFC00_0000, 0, 0, 0, 0, 0, 0);                  // opcode 0x3F

    repeat (2) tick;
    checkOutput("reset_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset_retire", {31'b0, retire}, 32'd0);
    checkOutput("reset_trap", {31'b0, trap}, 32'd0);
    checkOutput("reset_addr", mem_addr, 32'd0);
    checkOutput("reset_wdata", mem_wdata, 32'd0);
    checkOutput("reset_pc", pc, 32'h40);
    mon_en = 1'b1;
    reset  = 1'b0;

    n = 0;
    while (!trap && n < 2000) begin tick; n++; end
    checkOutput("trap_reached", {31'b0, trap}, 32'd1);
    repeat (3) begin
      tick;
      checkOutput("trap_sticky", {31'b0, trap}, 32'd1);
      checkOutput("trap_no_req", {31'b0, mem_req}, 32'd0);
    end
    checkOutput("rd_queue_drained", exp_rd.size(), 32'd0);
    checkOutput("wr_queue_drained", exp_wr.size(), 32'd0);
    checkOutput("gap_queue_drained", exp_gap.size(), 32'd0);

    // Clear the trap, let one fetch through, then stall the next fetch and reset in the middle of it
    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    checkOutput("reset_clears_trap", {31'b0, trap}, 32'd0);
    exp_rd.push_back(32'h40);
    n = 0;
    while (exp_rd.size() != 0 && n < 50) begin tick; n++; end
    stall = 1'b1;
    repeat (6) tick;
    checkOutput("stall_req", {31'b0, mem_req}, 32'd1);
    checkOutput("stall_addr", mem_addr, 32'h44);
    reset = 1'b1;
    tick;
    checkOutput("abort_req", {31'b0, mem_req}, 32'd0);
    checkOutput("abort_pc", pc, 32'h40);
    reset = 1'b0;
    stall = 1'b0;
    exp_rd.push_back(32'h40);
    n = 0;
    while (exp_rd.size() != 0 && n < 50) begin tick; n++; end
    mon_en = 1'b0;
    checkOutput("restart_fetch", exp_rd.size(), 32'd0);
    checkOutput("restart_trap", {31'b0, trap}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
